// File: rtl/led_bank_arbiter_pkg.sv
// Shared types and helpers for the LED bank arbiter.
// Holds the FSM encoding and a width helper used for counters and pointers.
package led_bank_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    // clog2 that never returns less than 1, so zero/one-sized counters stay legal
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/led_bank_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Rotates req by ptr, takes the lowest set bit, rotates the one-hot back.
module rr_pick
    import led_bank_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [N-1:0]  pick
);

    logic [N-1:0] rot;
    logic [N-1:0] first;
    logic         found;

    always_comb begin
        rot   = N'({req, req} >> ptr);
        first = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rot[i] && !found) begin
                first[i] = 1'b1;
                found    = 1'b1;
            end
        end
        pick  = N'(({first, first} << ptr) >> N);
        valid = |req;
    end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the shared LED/button bank with optional time slicing.
// Owner drives the registered LEDs and alone sees the synchronized buttons.
module led_bank_arbiter
    import led_bank_arbiter_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int LED_W     = 8,
    parameter int MAX_HOLD  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CLIENTS-1:0]       req,
    input  logic [N_CLIENTS*LED_W-1:0] led_data,
    input  logic [LED_W-1:0]           buttons,
    output logic [N_CLIENTS-1:0]       grant,
    output logic [LED_W-1:0]           leds,
    output logic [N_CLIENTS*LED_W-1:0] btn_out,
    output logic                       busy
);

    localparam int PW = clog2_min1(N_CLIENTS);
    localparam int HW = clog2_min1(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_SAT =
        (MAX_HOLD == 0) ? {HW{1'b1}} : HW'(MAX_HOLD - 1);

    state_t               state, nstate;
    logic [N_CLIENTS-1:0] grant_q;
    logic [PW-1:0]        owner;
    logic [PW-1:0]        ptr;
    logic [HW-1:0]        hold_cnt;
    logic [LED_W-1:0]     leds_q;
    logic [LED_W-1:0]     btn_s1;
    logic [LED_W-1:0]     btn_q;

    logic                 pick_valid;
    logic [N_CLIENTS-1:0] pick;
    logic [PW-1:0]        pick_idx;
    logic [PW-1:0]        ptr_nxt;
    logic                 preempt;

    rr_pick #(
        .N  (N_CLIENTS),
        .PW (PW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .pick  (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (pick[i]) begin
                pick_idx = PW'(i);
            end
        end
        ptr_nxt = (pick_idx == PW'(N_CLIENTS - 1)) ? '0 : pick_idx + 1'b1;
    end

    // Slice expiry only matters when someone else is actually waiting
    always_comb begin
        nstate  = state;
        preempt = (MAX_HOLD != 0) && (hold_cnt == HOLD_SAT)
                  && (|(req & ~grant_q));
        unique case (state)
            ST_IDLE: if (pick_valid) nstate = ST_OWN;
            ST_OWN:  if (!req[owner] || preempt) nstate = ST_IDLE;
            default: nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            grant_q  <= '0;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            leds_q   <= '0;
            btn_s1   <= '0;
            btn_q    <= '0;
        end else begin
            state  <= nstate;
            btn_s1 <= buttons;
            btn_q  <= btn_s1;
            unique case (state)
                ST_IDLE: begin
                    leds_q <= '0;
                    if (pick_valid) begin
                        grant_q  <= pick;
                        owner    <= pick_idx;
                        hold_cnt <= '0;
                        ptr      <= ptr_nxt;
                    end
                end
                ST_OWN: begin
                    leds_q <= led_data[int'(owner)*LED_W +: LED_W];
                    if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                    if (nstate == ST_IDLE) begin
                        grant_q <= '0;
                    end
                end
                default: grant_q <= '0;
            endcase
        end
    end

    always_comb begin
        btn_out = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (grant_q[i]) begin
                btn_out[i*LED_W +: LED_W] = btn_q;
            end
        end
    end

    assign grant = grant_q;
    assign leds  = leds_q;
    assign busy  = (state == ST_OWN);

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter (4 clients, 8-bit bus, 4-cycle slices).
// Table of per-edge vectors plus hand sequences for release and reset corners.
module tb_led_bank_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] led_data;
    logic [W-1:0]   buttons;
    logic [N-1:0]   grant;
    logic [W-1:0]   leds;
    logic [N*W-1:0] btn_out;
    logic           busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  g;
        logic [7:0]  l;
        logic        b;
        logic [31:0] bo;
    } vec_t;

    vec_t tbl[$];

    led_bank_arbiter #(
        .N_CLIENTS (N),
        .LED_W     (W),
        .MAX_HOLD  (MH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .led_data (led_data),
        .buttons  (buttons),
        .grant    (grant),
        .leds     (leds),
        .btn_out  (btn_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g,
                       input logic [7:0] l, input logic b,
                       input logic [31:0] bo);
        vec_t v;
        v.rst = r; v.req = q; v.g = g; v.l = l; v.b = b; v.bo = bo;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        buttons  = '0;
        // client 0=A5, 1=C3, 2=5A, 3=3C
        led_data = {8'h3C, 8'h5A, 8'hC3, 8'hA5};

        // Round robin with all four requesting, buttons held at 81
        add(1, 4'h0, 4'h0, 8'h00, 0, 32'h0000_0000);
        add(0, 4'hF, 4'h1, 8'h00, 1, 32'h0000_0000);
        add(0, 4'hF, 4'h1, 8'hA5, 1, 32'h0000_0081);
        add(0, 4'hF, 4'h1, 8'hA5, 1, 32'h0000_0081);
        add(0, 4'hF, 4'h1, 8'hA5, 1, 32'h0000_0081);
        add(0, 4'hF, 4'h0, 8'hA5, 0, 32'h0000_0000);
        add(0, 4'hF, 4'h2, 8'h00, 1, 32'h0000_8100);
        add(0, 4'hF, 4'h2, 8'hC3, 1, 32'h0000_8100);
        add(0, 4'hF, 4'h2, 8'hC3, 1, 32'h0000_8100);
        add(0, 4'hF, 4'h2, 8'hC3, 1, 32'h0000_8100);
        add(0, 4'hF, 4'h0, 8'hC3, 0, 32'h0000_0000);
        add(0, 4'hF, 4'h4, 8'h00, 1, 32'h0081_0000);
        add(0, 4'hF, 4'h4, 8'h5A, 1, 32'h0081_0000);
        add(0, 4'hF, 4'h4, 8'h5A, 1, 32'h0081_0000);
        add(0, 4'hF, 4'h4, 8'h5A, 1, 32'h0081_0000);
        add(0, 4'hF, 4'h0, 8'h5A, 0, 32'h0000_0000);
        add(0, 4'hF, 4'h8, 8'h00, 1, 32'h8100_0000);
        add(0, 4'hF, 4'h8, 8'h3C, 1, 32'h8100_0000);
        add(0, 4'hF, 4'h8, 8'h3C, 1, 32'h8100_0000);
        add(0, 4'hF, 4'h8, 8'h3C, 1, 32'h8100_0000);
        add(0, 4'hF, 4'h0, 8'h3C, 0, 32'h0000_0000);
        add(0, 4'hF, 4'h1, 8'h00, 1, 32'h0000_0081);
        add(0, 4'hF, 4'h1, 8'hA5, 1, 32'h0000_0081);

        // Reset then 50 idle cycles
        do_reset();
        chk("reset_state", {grant, leds, busy, btn_out}, 64'h0);
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle", {grant, leds, busy, btn_out}, 64'h0);
        end

        // Table-driven round robin
        buttons = 8'h81;
        for (int k = 0; k < tbl.size(); k++) begin
            rst = tbl[k].rst;
            req = tbl[k].req;
            step();
            chk($sformatf("rr%0d_grant", k), 64'(grant), 64'(tbl[k].g));
            chk($sformatf("rr%0d_leds", k), 64'(leds), 64'(tbl[k].l));
            chk($sformatf("rr%0d_busy", k), 64'(busy), 64'(tbl[k].b));
            chk($sformatf("rr%0d_btn", k), 64'(btn_out), 64'(tbl[k].bo));
        end

        // Single client: grant, LED latency, button sync latency
        do_reset();
        chk("t2_rst", {grant, leds, busy, btn_out}, 64'h0);
        req     = 4'b0001;
        buttons = 8'h03;
        step();
        chk("t2_grant", 64'(grant), 64'h1);
        chk("t2_leds0", 64'(leds), 64'h0);
        chk("t2_btn0", 64'(btn_out), 64'h0);
        step();
        chk("t2_leds", 64'(leds), 64'hA5);
        chk("t2_btn_lo", 64'(btn_out[7:0]), 64'h03);
        chk("t2_btn_hi", 64'(btn_out[31:8]), 64'h0);

        // Client 2 owns, drops req as client 0 arrives
        do_reset();
        req = 4'b0100;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("t4_own%0d", i), 64'(grant), 64'h4);
        end
        chk("t4_leds_own", 64'(leds), 64'h5A);
        req = 4'b0001;
        step();
        chk("t4_rel_grant", 64'(grant), 64'h0);
        chk("t4_rel_busy", 64'(busy), 64'h0);
        step();
        chk("t4_next_grant", 64'(grant), 64'h1);
        chk("t4_next_leds0", 64'(leds), 64'h0);
        step();
        chk("t4_next_leds", 64'(leds), 64'hA5);

        // Lone requester is never preempted
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("t5_hold%0d", i), 64'(grant), 64'h4);
        end
        chk("t5_hold_sat", 64'(dut.hold_cnt), 64'h3);

        // Reset during OWN of client 3, then priority restarts at 0
        do_reset();
        req = 4'b1000;
        step();
        step();
        chk("t6_own3", 64'(grant), 64'h8);
        rst = 1'b1;
        step();
        chk("t6_rst_out", {grant, leds, busy, btn_out}, 64'h0);
        chk("t6_rst_ptr", 64'(dut.ptr), 64'h0);
        rst = 1'b0;
        req = 4'b1010;
        step();
        chk("t6_first", 64'(grant), 64'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
